// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer for the EX stage
//
// Accepts MULT/MULTU/DIV/DIVU, stalls the pipeline while the operation runs,
// and owns the architectural HI/LO registers (also written by MTHI/MTLO).
// Multiply commits a fixed-latency product; divide runs a 32-step restoring
// divider on magnitudes, then fixes the signs in a separate SIGN cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i, op_i     mult/div request and opcode (00 MULT 01 MULTU 10 DIV 11 DIVU)
//   a_i, b_i          rs / rt operands
//   mthi_i, mtlo_i    write wdata_i into HI / LO
//   wdata_i           MTHI/MTLO data
//   flush_i           abort any operation in flight
//   stall_o           hold IF/ID/EX (combinational)
//   done_o            one-cycle pulse after HI/LO commit
//   hi_o, lo_o        architectural HI / LO
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, SIGN, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    // a_q holds the multiplicand, or the dividend magnitude that shifts into the quotient.
    // b_q holds the multiplier, or the divisor magnitude.
    logic [31:0] a_q, b_q;
    logic [31:0] rem;
    logic        mul_signed;
    logic        neg_q, neg_r;

    logic        accept;
    logic        div_signed_i;
    logic [31:0] ma, mb;
    logic [63:0] ax, bx, prod;
    logic [32:0] shifted, diff;
    logic [31:0] rem_nx, quo_nx;
    logic [31:0] q_fin, r_fin;

    assign accept       = (state == IDLE) && start_i && !flush_i;
    assign div_signed_i = (op_i == 2'b10);

    // Two's-complement abs; 0x80000000 maps to itself, read as unsigned 2^31.
    assign ma = (div_signed_i && a_i[31]) ? -a_i : a_i;
    assign mb = (div_signed_i && b_i[31]) ? -b_i : b_i;

    // Sign-extend to 64 bits for MULT; the low 64 bits of the product are then exact.
    assign ax   = {{32{mul_signed & a_q[31]}}, a_q};
    assign bx   = {{32{mul_signed & b_q[31]}}, b_q};
    assign prod = ax * bx;

    // Restoring step: since rem < divisor, the shifted value fits 33 bits and
    // diff[32] is a clean borrow flag.
    assign shifted = {rem, a_q[31]};
    assign diff    = shifted - {1'b0, b_q};

    always_comb begin
        rem_nx = diff[31:0];
        quo_nx = {a_q[30:0], 1'b1};
        if (diff[32]) begin
            rem_nx = shifted[31:0];
            quo_nx = {a_q[30:0], 1'b0};
        end
    end

    assign q_fin = neg_q ? -a_q : a_q;
    assign r_fin = neg_r ? -rem : rem;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (flush_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    if (!op_i[1])          state_nx = MUL;
                    else if (b_i != 32'd0) state_nx = DIV;
                    else                   state_nx = DONE;
                end
                MUL:     if (cnt == 5'd0) state_nx = DONE;
                DIV:     if (cnt == 5'd0) state_nx = SIGN;
                SIGN:    state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        stall_o = 1'b0;
        done_o  = 1'b0;
        if (!rst) begin
            stall_o = accept || (state == MUL) || (state == DIV) || (state == SIGN);
        end
        done_o = (state == DONE);
    end

    // Datapath and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 5'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rem        <= 32'd0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            hi_o       <= 32'd0;
            lo_o       <= 32'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mul_signed <= ~op_i[0];
                    a_q        <= op_i[1] ? ma : a_i;
                    b_q        <= op_i[1] ? mb : b_i;
                    rem        <= 32'd0;
                    neg_q      <= div_signed_i & (a_i[31] ^ b_i[31]);
                    neg_r      <= div_signed_i & a_i[31];
                    cnt        <= op_i[1] ? 5'd31 : 5'(MUL_LAT - 1);
                    if (op_i[1] && (b_i == 32'd0)) begin
                        hi_o <= a_i;
                        lo_o <= 32'hFFFF_FFFF;
                    end
                end
                MUL: if (!flush_i) begin
                    if (cnt == 5'd0) begin
                        hi_o <= prod[63:32];
                        lo_o <= prod[31:0];
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DIV: if (!flush_i) begin
                    a_q <= quo_nx;
                    rem <= rem_nx;
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                SIGN: if (!flush_i) begin
                    lo_o <= q_fin;
                    hi_o <= r_fin;
                end
                default: ;
            endcase
            // Placed last so an MT write overrides a same-edge divide-by-zero commit.
            if (((state == IDLE) || (state == DONE)) && !flush_i) begin
                if (mthi_i) hi_o <= wdata_i;
                if (mtlo_i) lo_o <= wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        mthi_i, mtlo_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o, done_o;
    logic [31:0] hi_o, lo_o;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        int          stall, done;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
    } res_t;

    vec_t vecs[12];
    res_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model built from plain 64-bit arithmetic.
    function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [63:0] sa, sbv, p;
        longint      q, m;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        case (op)
            2'd0: begin p = sa * sbv; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'd2: begin
                if (b == 0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin
                    q = longint'($signed(sa)) / longint'($signed(sbv));
                    m = longint'($signed(sa)) % longint'($signed(sbv));
                    r.lo = q[31:0]; r.hi = m[31:0];
                end
            end
            default: begin
                if (b == 0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin r.lo = a / b; r.hi = a % b; end
            end
        endcase
        return r;
    endfunction

    // Issues one op starting this cycle (aligned just after posedge), returns aligned after DONE.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int estall, input int edone);
        res_t r;
        int   scnt, dcyc;
        logic got;
        r.hi = ehi; r.lo = elo;
        sb.push_back(r);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        scnt = 0; dcyc = -1;
        for (int c = 0; c < 60; c++) begin
            #1;
            got = done_o;
            if (stall_o) scnt++;
            if (got) begin
                dcyc = c;
                r = sb.pop_front();
                check({name, "_hi"}, hi_o, r.hi);
                check({name, "_lo"}, lo_o, r.lo);
                start_i = 1'b0;
            end
            step();
            if (got) break;
        end
        start_i = 1'b0;
        if (dcyc < 0) begin
            $display("FAIL %s_timeout: no done_o within 60 cycles", name);
            void'(sb.pop_front());
        end
        check({name, "_stall_cycles"}, scnt, estall);
        check({name, "_done_cycle"}, dcyc, edone);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            #1;
            if (done_o) pulses++;
            step();
        end
        check({name, "_no_done"}, pulses, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_t m;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          lat;

        vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3, 3};
        vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 3, 3};
        vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 34};
        vecs[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 34};
        vecs[4]  = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1, 1};
        vecs[5]  = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 34, 34};
        vecs[6]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 34};
        vecs[7]  = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 34, 34};
        vecs[8]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3, 3};
        vecs[9]  = '{2'd1, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 3, 3};
        vecs[10] = '{2'd2, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 34, 34};
        vecs[11] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 1};

        rst = 1'b1; start_i = 1'b1; op_i = 2'd0; a_i = 32'd3; b_i = 32'd4;
        mthi_i = 1'b0; mtlo_i = 1'b0; wdata_i = 32'd0; flush_i = 1'b0;
        step(); step();
        #1 check("stall_during_rst", stall_o, 0);
        rst = 1'b0; start_i = 1'b0;
        step();
        #1;
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_done", done_o, 0);
        step();

        // Back-to-back table ops: each starts in the IDLE cycle after the previous DONE.
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].stall, vecs[i].done);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 6) rb = 32'd0;
            m   = model(rop, ra, rb);
            lat = (rop < 2) ? MUL_LAT + 1 : ((rb == 0) ? 1 : 34);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, m.hi, m.lo, lat, lat);
        end

        // MULT then MTLO in IDLE
        run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 3, 3);
        mtlo_i = 1'b1; wdata_i = 32'h12345678;
        step();
        mtlo_i = 1'b0;
        #1;
        check("mtlo_lo", lo_o, 32'h12345678);
        check("mtlo_hi_kept", hi_o, 32'hFFFFFFFF);
        step();

        // MT ignored in MUL; start held through DONE ignored; MTHI in DONE applied.
        start_i = 1'b1; op_i = 2'd1; a_i = 32'd3; b_i = 32'd4;
        step();
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hDEADBEEF;
        step();
        mthi_i = 1'b0; mtlo_i = 1'b0;
        step();
        #1;
        check("mt_in_mul_done", done_o, 1);
        check("mt_in_mul_hi", hi_o, 32'h0);
        check("mt_in_mul_lo", lo_o, 32'hC);
        mthi_i = 1'b1; wdata_i = 32'hA5A5A5A5;
        step();
        mthi_i = 1'b0; start_i = 1'b0;
        #1;
        check("start_in_done_ignored", stall_o, 0);
        check("mthi_in_done_hi", hi_o, 32'hA5A5A5A5);
        check("mthi_in_done_lo", lo_o, 32'hC);
        step();

        // Known HI/LO, then flush in IDLE blocks a divide-by-zero start.
        mthi_i = 1'b1; wdata_i = 32'h11111111;
        step();
        mthi_i = 1'b0; mtlo_i = 1'b1; wdata_i = 32'h22222222;
        step();
        mtlo_i = 1'b0;
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'd3; a_i = 32'd100; b_i = 32'd0;
        #1 check("flush_idle_stall", stall_o, 0);
        step();
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        check("flush_idle_done", done_o, 0);
        check("flush_idle_hi", hi_o, 32'h11111111);
        check("flush_idle_lo", lo_o, 32'h22222222);
        step();

        // DIVU 100/7 flushed at cycle 10.
        start_i = 1'b1; op_i = 2'd3; a_i = 32'd100; b_i = 32'd7;
        for (int c = 0; c < 10; c++) step();
        start_i = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("flush_div_stall", stall_o, 0);
        check("flush_div_done", done_o, 0);
        step();
        watch_no_done("flush_div", 40);
        #1;
        check("flush_div_hi", hi_o, 32'h11111111);
        check("flush_div_lo", lo_o, 32'h22222222);
        step();
        run_op("divu_after_flush", 2'd3, 32'd100, 32'd7, 32'h2, 32'hE, 34, 34);

        // Reset at cycle 5 of a DIV.
        start_i = 1'b1; op_i = 2'd2; a_i = 32'hFFFFFFF9; b_i = 32'd2;
        for (int c = 0; c < 5; c++) step();
        rst = 1'b1;
        #1 check("rst_mid_div_stall_in_rst", stall_o, 0);
        step();
        rst = 1'b0; start_i = 1'b0;
        #1;
        check("rst_mid_div_stall", stall_o, 0);
        check("rst_mid_div_hi", hi_o, 32'h0);
        check("rst_mid_div_lo", lo_o, 32'h0);
        check("rst_mid_div_done", done_o, 0);
        step();
        watch_no_done("rst_mid_div", 40);
        run_op("after_rst", 2'd1, 32'h80000000, 32'h2, 32'h1, 32'h0, 3, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
